// File: rtl/adma2_engine.sv
// ADMA2 descriptor engine: walks a linked descriptor list in system RAM and moves
// 32-bit words between RAM and the SD data FIFO over a req/ack memory port.
module adma2_engine #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              stop_req,
  input  logic              direction,
  input  logic [ADDR_W-1:0] desc_base,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              fifo_wr,
  output logic [31:0]       fifo_wdata,
  input  logic              fifo_full,
  output logic              fifo_rd,
  input  logic [31:0]       fifo_rdata,
  input  logic              fifo_empty,
  output logic              busy,
  output logic              int_irq,
  output logic              done_irq,
  output logic              err_irq,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] desc_ptr
);
  localparam logic [2:0] ST_STOP = 3'd0;
  localparam logic [2:0] ST_FDS  = 3'd1;
  localparam logic [2:0] ST_CADR = 3'd2;
  localparam logic [2:0] ST_TFR  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [1:0]        LAST_WORD  = (ADDR_W > 32) ? 2'd2 : 2'd1;
  localparam logic [ADDR_W-1:0] DESC_BYTES = ADDR_W'((ADDR_W > 32) ? 12 : 8);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] desc_ptr_q, desc_ptr_d;
  logic [1:0]        fidx_q, fidx_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [LEN_W:0]    beats_q, beats_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              int_irq_q, int_irq_d;
  logic              done_irq_q, done_irq_d;
  logic              err_irq_q, err_irq_d;
  logic              dir_q, dir_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        act_q, act_d;
  logic              int_q, int_d, end_q, end_d, valid_q, valid_d;
  logic [31:0]       alo_q, alo_d, ahi_q, ahi_d;

  logic [ADDR_W-1:0] desc_addr;
  logic              retire, is_link, fifo_wr_c, fifo_rd_c;

  assign desc_addr = ADDR_W'({ahi_q, alo_q});
  assign is_link   = (state_q == ST_CADR) && (act_q == 2'b11);

  always_comb begin
    state_d    = state_q;
    desc_ptr_d = desc_ptr_q;
    fidx_d     = fidx_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    beats_d    = beats_q;
    err_code_d = err_code_q;
    int_irq_d  = 1'b0;
    done_irq_d = 1'b0;
    err_irq_d  = 1'b0;
    dir_d      = dir_q;
    len_d      = len_q;
    act_d      = act_q;
    int_d      = int_q;
    end_d      = end_q;
    valid_d    = valid_q;
    alo_d      = alo_q;
    ahi_d      = ahi_q;
    retire     = 1'b0;
    fifo_wr_c  = 1'b0;
    fifo_rd_c  = 1'b0;

    case (state_q)
      ST_STOP, ST_ERR: begin
        if (start) begin
          state_d    = ST_FDS;
          desc_ptr_d = desc_base;
          err_code_d = 2'b00;
          fidx_d     = 2'd0;
          dir_d      = direction;
        end
      end
      ST_FDS: begin
        if (req_q) begin
          if (mem_ack) begin
            req_d = 1'b0;
            case (fidx_q)
              2'd0: begin
                len_d   = mem_rdata[LEN_W+15:16];
                act_d   = mem_rdata[5:4];
                int_d   = mem_rdata[2];
                end_d   = mem_rdata[1];
                valid_d = mem_rdata[0];
              end
              2'd1:    alo_d = mem_rdata;
              default: ahi_d = mem_rdata;
            endcase
            if (fidx_q == LAST_WORD) begin
              state_d = ST_CADR;
              fidx_d  = 2'd0;
            end else begin
              fidx_d = fidx_q + 2'd1;
            end
          end
        end else if (stop_req) begin
          state_d = ST_STOP;
        end else begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = desc_ptr_q + ADDR_W'({fidx_q, 2'b00});
        end
      end
      ST_CADR: begin
        if (!valid_q) begin
          state_d    = ST_ERR;
          err_code_d = 2'b01;
          err_irq_d  = 1'b1;
        end else if (act_q == 2'b10) begin
          if (desc_addr[1:0] != 2'b00) begin
            state_d    = ST_ERR;
            err_code_d = 2'b10;
            err_irq_d  = 1'b1;
          end else begin
            state_d = ST_TFR;
            addr_d  = desc_addr;
            beats_d = (len_q == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_q};
          end
        end else begin
          if (act_q == 2'b11) desc_ptr_d = desc_addr;
          retire = 1'b1;
        end
      end
      ST_TFR: begin
        if (req_q) begin
          if (mem_ack) begin
            req_d     = 1'b0;
            we_d      = 1'b0;
            fifo_wr_c = dir_q;
            beats_d   = beats_q - 1'b1;
            addr_d    = addr_q + ADDR_W'(4);
            if (beats_q == (LEN_W+1)'(1)) retire = 1'b1;
          end
        end else if (stop_req) begin
          state_d = ST_STOP;
        end else if (dir_q) begin
          if (!fifo_full) begin
            req_d = 1'b1;
            we_d  = 1'b0;
          end
        end else if (!fifo_empty) begin
          // Pop now, write the latched word starting next cycle.
          fifo_rd_c = 1'b1;
          wdata_d   = fifo_rdata;
          req_d     = 1'b1;
          we_d      = 1'b1;
        end
      end
      default: state_d = ST_STOP;
    endcase

    if (retire) begin
      int_irq_d = int_q;
      if (end_q || stop_req) begin
        state_d    = ST_STOP;
        done_irq_d = end_q;
      end else begin
        state_d = ST_FDS;
        if (!is_link) desc_ptr_d = desc_ptr_q + DESC_BYTES;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_STOP;
      desc_ptr_q <= '0;
      fidx_q     <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      beats_q    <= '0;
      err_code_q <= 2'b00;
      int_irq_q  <= 1'b0;
      done_irq_q <= 1'b0;
      err_irq_q  <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      desc_ptr_q <= desc_ptr_d;
      fidx_q     <= fidx_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      beats_q    <= beats_d;
      err_code_q <= err_code_d;
      int_irq_q  <= int_irq_d;
      done_irq_q <= done_irq_d;
      err_irq_q  <= err_irq_d;
      dir_q      <= dir_d;
    end
    len_q   <= len_d;
    act_q   <= act_d;
    int_q   <= int_d;
    end_q   <= end_d;
    valid_q <= valid_d;
    alo_q   <= alo_d;
    ahi_q   <= ahi_d;
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign fifo_wr    = fifo_wr_c;
  assign fifo_wdata = fifo_wr_c ? mem_rdata : 32'h0;
  assign fifo_rd    = fifo_rd_c;
  assign busy       = (state_q != ST_STOP) && (state_q != ST_ERR);
  assign int_irq    = int_irq_q;
  assign done_irq   = done_irq_q;
  assign err_irq    = err_irq_q;
  assign err_code   = err_code_q;
  assign desc_ptr   = desc_ptr_q;

endmodule

// File: tb/tb_adma2_engine.sv
// Scoreboard bench for adma2_engine: a 64-bit instance (a_*) and a 32-bit, LEN_W=4
// instance (b_*), each with a one-cycle-latency memory responder.
module tb_adma2_engine;
  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [31:0] data;
  } mtx_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  // 64-bit instance
  logic        a_start, a_dir, a_req, a_we, a_ack = 1'b0, a_fwr, a_frd, a_busy, a_int, a_done, a_err;
  logic [63:0] a_base, a_addr, a_dptr;
  logic [31:0] a_wdata, a_rdata = 32'h0, a_fwdata;
  logic [1:0]  a_ecode;
  logic        a_stop = 1'b0;
  logic [31:0] mem_a [logic [63:0]];

  // 32-bit instance
  logic        b_start, b_dir, b_stop, b_req, b_we, b_ack = 1'b0, b_fwr, b_frd, b_busy, b_int, b_done, b_err;
  logic [31:0] b_base, b_addr, b_dptr;
  logic [31:0] b_wdata, b_rdata = 32'h0, b_fwdata, b_frdata;
  logic        b_fempty;
  logic [1:0]  b_ecode;
  logic [31:0] mem_b [logic [31:0]];
  logic [31:0] b_fsrc [3];
  int          b_fidx = 0;
  int          b_favail = 0;

  mtx_t        qa_mem[$], qb_mem[$];
  logic [31:0] qa_fifo[$], qb_fifo[$];
  int a_nfifo = 0, a_nint = 0, a_ndone = 0, a_nboth = 0;
  int b_nfifo = 0, b_nint = 0, b_ndone = 0, b_nboth = 0, b_nerr = 0, b_nwr = 0, b_viol = 0;
  logic b_prev_req = 1'b0, b_prev_empty = 1'b0;

  adma2_engine #(.ADDR_W(64), .LEN_W(16)) u_a (
    .CLK(CLK), .RESET(RESET), .start(a_start), .stop_req(a_stop), .direction(a_dir),
    .desc_base(a_base), .mem_req(a_req), .mem_we(a_we), .mem_addr(a_addr),
    .mem_wdata(a_wdata), .mem_ack(a_ack), .mem_rdata(a_rdata), .fifo_wr(a_fwr),
    .fifo_wdata(a_fwdata), .fifo_full(1'b0), .fifo_rd(a_frd), .fifo_rdata(32'h0),
    .fifo_empty(1'b1), .busy(a_busy), .int_irq(a_int), .done_irq(a_done),
    .err_irq(a_err), .err_code(a_ecode), .desc_ptr(a_dptr)
  );

  adma2_engine #(.ADDR_W(32), .LEN_W(4)) u_b (
    .CLK(CLK), .RESET(RESET), .start(b_start), .stop_req(b_stop), .direction(b_dir),
    .desc_base(b_base), .mem_req(b_req), .mem_we(b_we), .mem_addr(b_addr),
    .mem_wdata(b_wdata), .mem_ack(b_ack), .mem_rdata(b_rdata), .fifo_wr(b_fwr),
    .fifo_wdata(b_fwdata), .fifo_full(1'b0), .fifo_rd(b_frd), .fifo_rdata(b_frdata),
    .fifo_empty(b_fempty), .busy(b_busy), .int_irq(b_int), .done_irq(b_done),
    .err_irq(b_err), .err_code(b_ecode), .desc_ptr(b_dptr)
  );

  function automatic logic [31:0] ram_word(input logic [63:0] addr);
    return addr[31:0] ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] dw0(input int len, input logic [1:0] act,
                                      input logic intf, input logic endf, input logic valid);
    return (32'(len) << 16) | {26'b0, act, 1'b0, intf, endf, valid};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic exp_rd(input logic is_b, input logic [63:0] addr);
    mtx_t m;
    m = '{we: 1'b0, addr: addr, data: 32'h0};
    if (is_b) qb_mem.push_back(m); else qa_mem.push_back(m);
  endtask

  task automatic exp_data_rd(input logic is_b, input logic [63:0] addr);
    exp_rd(is_b, addr);
    if (is_b) qb_fifo.push_back(ram_word(addr)); else qa_fifo.push_back(ram_word(addr));
  endtask

  // Memory responders: ack one cycle after req, data valid in the ack cycle.
  assign b_frdata = (b_fidx < 3) ? b_fsrc[b_fidx] : 32'h0;
  assign b_fempty = (b_fidx >= b_favail);

  always @(posedge CLK) begin
    a_ack   <= a_req && !a_ack;
    a_rdata <= mem_a.exists(a_addr) ? mem_a[a_addr] : ram_word(a_addr);
    b_ack   <= b_req && !b_ack;
    b_rdata <= mem_b.exists(b_addr) ? mem_b[b_addr] : ram_word(64'(b_addr));
    if (b_frd) b_fidx <= b_fidx + 1;
  end

  always @(negedge CLK) begin
    mtx_t m;
    logic [31:0] d;
    if (a_req && a_ack) begin
      if (qa_mem.size() == 0) chk("A_mem_unexpected", 64'(qa_mem.size()), 64'd1);
      else begin
        m = qa_mem.pop_front();
        chk("A_mem_addr", a_addr, m.addr);
        chk("A_mem_we", 64'(a_we), 64'(m.we));
      end
    end
    if (a_fwr) begin
      a_nfifo++;
      if (qa_fifo.size() == 0) chk("A_fifo_unexpected", 64'(qa_fifo.size()), 64'd1);
      else begin
        d = qa_fifo.pop_front();
        chk("A_fifo_data", 64'(a_fwdata), 64'(d));
      end
    end
    if (a_int) a_nint++;
    if (a_done) a_ndone++;
    if (a_int && a_done) a_nboth++;

    if (b_req && b_ack) begin
      if (b_we) b_nwr++;
      if (qb_mem.size() == 0) chk("B_mem_unexpected", 64'(qb_mem.size()), 64'd1);
      else begin
        m = qb_mem.pop_front();
        chk("B_mem_addr", 64'(b_addr), m.addr);
        chk("B_mem_we", 64'(b_we), 64'(m.we));
        if (m.we) chk("B_mem_wdata", 64'(b_wdata), 64'(m.data));
      end
    end
    if (b_fwr) begin
      b_nfifo++;
      if (qb_fifo.size() == 0) chk("B_fifo_unexpected", 64'(qb_fifo.size()), 64'd1);
      else begin
        d = qb_fifo.pop_front();
        chk("B_fifo_data", 64'(b_fwdata), 64'(d));
      end
    end
    if (b_int) b_nint++;
    if (b_done) b_ndone++;
    if (b_err) b_nerr++;
    if (b_int && b_done) b_nboth++;
    if (b_req && b_we && !b_prev_req && b_prev_empty) b_viol++;
    b_prev_req   = b_req;
    b_prev_empty = b_fempty;
  end

  task automatic start_a(input logic [63:0] base, input logic dir);
    a_base = base; a_dir = dir;
    @(negedge CLK) a_start = 1'b1;
    @(negedge CLK) a_start = 1'b0;
  endtask

  task automatic start_b(input logic [31:0] base, input logic dir);
    b_base = base; b_dir = dir;
    @(negedge CLK) b_start = 1'b1;
    @(negedge CLK) b_start = 1'b0;
  endtask

  task automatic wait_idle(input logic is_b, input string tag);
    int n;
    n = 0;
    while ((is_b ? b_busy : a_busy) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 2000) chk({tag, "_timeout"}, 64'(n), 64'd0);
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_b_fifo(input int target, input string tag);
    int n;
    n = 0;
    while (b_nfifo < target && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 500) chk({tag, "_fifo_timeout"}, 64'(b_nfifo), 64'(target));
  endtask

  // Returns at the first negedge, after at least one cycle, where b_req is high.
  task automatic wait_b_req(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!b_req && n < 50);
    if (n >= 50) chk({tag, "_req_timeout"}, 64'(b_req), 64'd1);
  endtask

  initial begin
    int s_int, s_done, s_both, s_fifo, s_err;
    RESET = 1'b1;
    a_start = 1'b0; a_dir = 1'b1; a_base = '0;
    b_start = 1'b0; b_dir = 1'b1; b_base = '0; b_stop = 1'b0;
    for (int i = 0; i < 3; i++) b_fsrc[i] = 32'hF1F0_0000 + 32'(i);

    mem_a[64'h100] = dw0(4, 2'b10, 1'b1, 1'b1, 1'b1);
    mem_a[64'h104] = 32'h0000_1000;
    mem_a[64'h108] = 32'h0;
    mem_b[32'h000] = dw0(0, 2'b11, 1'b0, 1'b0, 1'b1);
    mem_b[32'h004] = 32'h0000_0200;
    mem_b[32'h200] = dw0(0, 2'b00, 1'b0, 1'b1, 1'b1);
    mem_b[32'h204] = 32'h0;
    mem_b[32'h300] = dw0(3, 2'b10, 1'b0, 1'b1, 1'b1);
    mem_b[32'h304] = 32'h0000_2000;
    mem_b[32'h400] = dw0(1, 2'b10, 1'b0, 1'b1, 1'b0);
    mem_b[32'h404] = 32'h0000_2100;
    mem_b[32'h480] = dw0(1, 2'b10, 1'b0, 1'b1, 1'b1);
    mem_b[32'h484] = 32'h0000_2102;
    mem_b[32'h500] = dw0(0, 2'b01, 1'b0, 1'b1, 1'b1);
    mem_b[32'h504] = 32'h0;
    mem_b[32'h600] = dw0(8, 2'b10, 1'b0, 1'b1, 1'b1);
    mem_b[32'h604] = 32'h0000_3000;
    mem_b[32'h700] = dw0(0, 2'b10, 1'b1, 1'b1, 1'b1);
    mem_b[32'h704] = 32'h0000_4000;

    repeat (3) @(negedge CLK);
    chk("rst_A_ctrl", 64'({a_req, a_we, a_fwr, a_frd, a_busy, a_int, a_done, a_err, a_ecode}), 64'd0);
    chk("rst_A_addr", a_addr, 64'd0);
    chk("rst_A_dptr", a_dptr, 64'd0);
    chk("rst_B_ctrl", 64'({b_req, b_we, b_fwr, b_frd, b_busy, b_int, b_done, b_err, b_ecode}), 64'd0);
    chk("rst_B_data", {b_addr, b_wdata}, 64'd0);
    RESET = 1'b0;

    // 1: 64-bit single TRAN, RAM->FIFO, INT+END together
    exp_rd(1'b0, 64'h100); exp_rd(1'b0, 64'h104); exp_rd(1'b0, 64'h108);
    for (int i = 0; i < 4; i++) exp_data_rd(1'b0, 64'h1000 + 64'(4 * i));
    start_a(64'h100, 1'b1);
    wait_idle(1'b0, "T1");
    chk("T1_nfifo", 64'(a_nfifo), 64'd4);
    chk("T1_int_done_same", 64'({a_nint, a_ndone, a_nboth} != 0 ? a_nboth : 0), 64'd1);
    chk("T1_busy", 64'(a_busy), 64'd0);
    chk("T1_q_empty", 64'(qa_mem.size() + qa_fifo.size()), 64'd0);

    // 2: 32-bit LINK then NOP END
    s_done = b_ndone; s_fifo = b_nfifo;
    exp_rd(1'b1, 64'h0); exp_rd(1'b1, 64'h4); exp_rd(1'b1, 64'h200); exp_rd(1'b1, 64'h204);
    start_b(32'h0, 1'b1);
    wait_idle(1'b1, "T2");
    chk("T2_done", 64'(b_ndone - s_done), 64'd1);
    chk("T2_nfifo", 64'(b_nfifo - s_fifo), 64'd0);
    chk("T2_dptr", 64'(b_dptr), 64'h200);
    chk("T2_q_empty", 64'(qb_mem.size()), 64'd0);

    // 3: FIFO->RAM with a FIFO-empty stall mid-transfer
    s_done = b_ndone;
    b_favail = 1;
    exp_rd(1'b1, 64'h300); exp_rd(1'b1, 64'h304);
    for (int i = 0; i < 3; i++) qb_mem.push_back('{we: 1'b1, addr: 64'h2000 + 64'(4 * i), data: b_fsrc[i]});
    start_b(32'h300, 1'b0);
    for (int n = 0; n < 500 && b_nwr < 1; n++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    b_favail = 3;
    wait_idle(1'b1, "T3");
    chk("T3_writes", 64'(b_nwr), 64'd3);
    chk("T3_popped", 64'(b_fidx), 64'd3);
    chk("T3_req_while_empty", 64'(b_viol), 64'd0);
    chk("T3_done", 64'(b_ndone - s_done), 64'd1);
    chk("T3_q_empty", 64'(qb_mem.size()), 64'd0);

    // 4: invalid, misaligned, then clean restart
    s_err = b_nerr;
    exp_rd(1'b1, 64'h400); exp_rd(1'b1, 64'h404);
    start_b(32'h400, 1'b1);
    wait_idle(1'b1, "T4a");
    chk("T4_err_code_inv", 64'(b_ecode), 64'd1);
    chk("T4_err_irq", 64'(b_nerr - s_err), 64'd1);
    chk("T4_busy", 64'(b_busy), 64'd0);
    exp_rd(1'b1, 64'h480); exp_rd(1'b1, 64'h484);
    start_b(32'h480, 1'b1);
    wait_idle(1'b1, "T4b");
    chk("T4_err_code_mis", 64'(b_ecode), 64'd2);
    s_done = b_ndone;
    exp_rd(1'b1, 64'h500); exp_rd(1'b1, 64'h504);
    start_b(32'h500, 1'b1);
    chk("T4_restart_code", 64'(b_ecode), 64'd0);
    chk("T4_restart_ptr", 64'(b_dptr), 64'h500);
    wait_idle(1'b1, "T4c");
    chk("T4_done", 64'(b_ndone - s_done), 64'd1);
    chk("T4_q_empty", 64'(qb_mem.size()), 64'd0);

    // 5: stop_req while the 2nd of 8 reads is outstanding
    s_done = b_ndone; s_fifo = b_nfifo; s_int = b_nint;
    exp_rd(1'b1, 64'h600); exp_rd(1'b1, 64'h604);
    exp_data_rd(1'b1, 64'h3000); exp_data_rd(1'b1, 64'h3004);
    start_b(32'h600, 1'b1);
    wait_b_fifo(s_fifo + 1, "T5");
    wait_b_req("T5");
    b_stop = 1'b1;
    wait_idle(1'b1, "T5");
    b_stop = 1'b0;
    chk("T5_nfifo", 64'(b_nfifo - s_fifo), 64'd2);
    chk("T5_no_done", 64'(b_ndone - s_done + b_nint - s_int), 64'd0);
    chk("T5_q_empty", 64'(qb_mem.size() + qb_fifo.size()), 64'd0);

    // 6: RESET with a read outstanding, then length 0 -> 16 beats
    s_fifo = b_nfifo;
    exp_rd(1'b1, 64'h700); exp_rd(1'b1, 64'h704);
    exp_data_rd(1'b1, 64'h4000); exp_data_rd(1'b1, 64'h4004);
    start_b(32'h700, 1'b1);
    wait_b_fifo(s_fifo + 2, "T6a");
    wait_b_req("T6a");
    RESET = 1'b1;
    @(negedge CLK);
    chk("T6_rst_ctrl", 64'({b_req, b_we, b_fwr, b_frd, b_busy, b_int, b_done, b_err, b_ecode}), 64'd0);
    chk("T6_rst_data", {b_addr, b_dptr}, 64'd0);
    RESET = 1'b0;
    chk("T6a_q_empty", 64'(qb_mem.size() + qb_fifo.size()), 64'd0);
    s_fifo = b_nfifo; s_both = b_nboth;
    exp_rd(1'b1, 64'h700); exp_rd(1'b1, 64'h704);
    for (int i = 0; i < 16; i++) exp_data_rd(1'b1, 64'h4000 + 64'(4 * i));
    start_b(32'h700, 1'b1);
    wait_idle(1'b1, "T6b");
    chk("T6_beats", 64'(b_nfifo - s_fifo), 64'd16);
    chk("T6_int_done_same", 64'(b_nboth - s_both), 64'd1);
    chk("T6_q_empty", 64'(qb_mem.size() + qb_fifo.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/adma2_engine.md
Name: adma2_engine

Overview:
- Parametrised successor to the single-channel ADMA state machine.
- Walks a linked list of ADMA2 descriptors in system RAM and moves 32-bit words between RAM and the SD data FIFO in either direction.
- Supports 32- or 64-bit descriptor addressing, a req/ack memory handshake, and error detection with an error state.
- Raises interrupt pulses on descriptor INT, list END and error.

Parameters:
- ADDR_W, 64, system address width; 32 selects 8-byte descriptors (2 words), 64 selects 12-byte descriptors (3 words).
- LEN_W, 16, descriptor length field width, in words; length 0 encodes 2^LEN_W words.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- start  in  1  one-cycle pulse; begins a list walk at desc_base. Ignored unless in ST_STOP or ST_ERR.
- stop_req  in  1  level; requests an orderly abort.
- direction  in  1  1 = RAM->FIFO, 0 = FIFO->RAM.
- desc_base  in  ADDR_W  address of the first descriptor; must be word aligned.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req is high.
- mem_addr  out  ADDR_W  word-aligned byte address; stable while mem_req is high.
- mem_wdata  out  32  write data; stable while mem_req is high.
- mem_ack  in  1  completes the request; mem_rdata is valid in the ack cycle.
- mem_rdata  in  32  read data.
- fifo_wr  out  1  one-cycle push of fifo_wdata.
- fifo_wdata  out  32  FIFO write data.
- fifo_full  in  1  FIFO cannot accept a push.
- fifo_rd  out  1  one-cycle pop; fifo_rdata is consumed in the same cycle.
- fifo_rdata  in  32  FIFO head word, valid while !fifo_empty.
- fifo_empty  in  1  FIFO has no data.
- busy  out  1  high in every state except ST_STOP and ST_ERR.
- int_irq  out  1  one-cycle pulse; descriptor with INT=1 retired.
- done_irq  out  1  one-cycle pulse; descriptor with END=1 retired.
- err_irq  out  1  one-cycle pulse on entry to ST_ERR.
- err_code  out  2  00 none, 01 invalid descriptor, 10 misaligned address, 11 memory fault reserved (never driven).
- desc_ptr  out  ADDR_W  address of the current descriptor.

Behaviour:
- Reset is synchronous, active-high, on RESET; clock is CLK. RESET wins over every other input, including mid-transfer; any outstanding mem_req is dropped.
- Reset values: state ST_STOP; every output 0.
- Descriptor word 0: [LEN_W+15:16] length, [5:4] ACT, [2] INT, [1] END, [0] VALID. Word 1: address[31:0]. Word 2 (ADDR_W=64 only): address[63:32].
- States: ST_STOP, ST_FDS (fetch), ST_CADR (decode), ST_TFR (transfer), ST_ERR.
- ST_STOP/ST_ERR + start -> ST_FDS next cycle. On that edge: desc_ptr <= desc_base, err_code <= 0.
- ST_FDS:
  - Issues 2 or 3 read requests at desc_ptr, +4, +8.
  - mem_req drops in the cycle after each ack, giving at least one idle cycle between requests.
  - After the last ack -> ST_CADR.
- ST_CADR (1 cycle):
  - VALID=0 -> ST_ERR with err_code 01.
  - ACT=10 (TRAN): transfer address[1:0]!=0 -> ST_ERR with err_code 10; otherwise -> ST_TFR, with beat counter loaded from length and mem_addr loaded from address.
  - ACT=00 or 01 (NOP/RSV): retire the descriptor.
  - ACT=11 (LINK): desc_ptr <= address, then retire.
- Retire (shared by ST_CADR and ST_TFR):
  - int_irq pulses if INT=1.
  - If END=1 or stop_req: -> ST_STOP, with done_irq pulsed only if END=1.
  - Otherwise -> ST_FDS; desc_ptr advances by 8 or 12, except after LINK.
- ST_TFR, RAM->FIFO, one beat:
  - Assert a read only when !fifo_full and no request is outstanding.
  - In the ack cycle: fifo_wr=1 and fifo_wdata=mem_rdata.
- ST_TFR, FIFO->RAM, one beat:
  - When !fifo_empty and no request is outstanding: pulse fifo_rd and latch fifo_rdata.
  - Next cycle: assert a write of the latched word until ack.
- Beat accounting: each ack decrements the beat counter and advances the address by 4. The address wraps modulo 2^ADDR_W with no error. When the counter reaches 0 the descriptor retires.
- stop_req: sampled only between beats or between fetch words. An outstanding request always completes, and its data is pushed or written, before -> ST_STOP. No done_irq is generated.
- Simultaneous INT and END on one descriptor: int_irq and done_irq pulse in the same cycle.

Test Plan:
1. ADDR_W=64. Single TRAN descriptor {len=4, END=1, INT=1, addr=0x1000}, direction=1, FIFO never full -> 4 reads at 0x1000..0x100C, 4 fifo_wr with the RAM data in order, int_irq and done_irq in the same cycle, then busy=0.
2. ADDR_W=32. LINK at 0x0 pointing to 0x200, then NOP END at 0x200 -> descriptor fetches at 0x0, 0x4, 0x200, 0x204 only; done_irq=1; no data traffic.
3. FIFO->RAM with len=3. fifo_empty high for 5 cycles mid-transfer -> no mem_req while empty; 3 writes at addr..addr+8 carrying the FIFO words in order.
4. Descriptor with VALID=0 -> err_irq pulse, err_code=01, busy=0. A following start restarts from desc_base with err_code=0.
5. stop_req asserted while the 2nd of 8 reads is outstanding -> that read completes and is pushed, exactly 2 fifo_wr, ST_STOP, no done_irq.
6. RESET during ST_TFR with mem_req high -> next cycle all outputs 0 and state ST_STOP; length=0 with LEN_W=4 -> exactly 16 beats.
